ddr2_rr_arbiter: RTL and testbench
==================================

// Module: ddr2_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the DDR2 address FIFO (af) and write-data FIFO (wdf) among NREQ clients
//  (icache, dcache, pixel feeder, graphics engines), one transaction at a time.
//  Records the owner of every read in an in-order tag FIFO and steers read-data FIFO (rdf) beats back to it.
//  Sits between the client blocks and the mig_af/mig_wdf/mig_rdf clock-crossing FIFOs, in the cpu clock domain.
// PARAMETERS
//  NREQ       4   number of requesters; index 0..NREQ-1
//  TAG_DEPTH  8   max outstanding reads (power of 2)
//  TAG_W      2   clog2(NREQ), width of one stored owner index
// PORTS
//  clk            in   1          cpu clock; all logic on rising edge
//  rst            in   1          asynchronous, active-low reset
//  req            in   NREQ       client i has a transaction pending
//  req_af_wr_en   in   NREQ       client af write strobe
//  req_af_cmd     in   3*NREQ     client command, slice i = [3i+2:3i]; 3'b000 write, 3'b001 read
//  req_af_addr    in   31*NREQ    client address, slice i
//  req_wdf_wr_en  in   NREQ       client wdf write strobe
//  req_wdf_din    in   128*NREQ   client write data, slice i
//  req_wdf_mask   in   16*NREQ    client byte mask, slice i
//  req_rdf_rd_en  in   NREQ       client rdf pop
//  req_af_full    out  NREQ       per-client af full; 1 unless granted in CMD
//  req_wdf_full   out  NREQ       per-client wdf full; 1 unless granted in WR0/WR1
//  req_rdf_valid  out  NREQ       rdf_valid steered to owner of oldest outstanding read
//  af_full, wdf_full, rdf_valid  in  1 each   downstream FIFO status
//  af_wr_en/af_cmd_din/af_addr_din  out  1/3/31   downstream af write
//  wdf_wr_en/wdf_din/wdf_mask_din   out  1/128/16 downstream wdf write
//  rdf_rd_en      out  1          downstream rdf pop
//  outstanding    out  TAG_W+2    reads issued, not yet fully returned (0..TAG_DEPTH)
//  orphan_err     out  1          sticky: rdf_valid seen with tag FIFO empty
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, no grant, last_grant=NREQ-1, tag FIFO empty, beat=0, orphan_err=0.
//   Outputs held: req_af_full=all 1, req_wdf_full=all 1, req_rdf_valid=0, af_wr_en=wdf_wr_en=rdf_rd_en=0.
//   Reset mid-transaction abandons it; outstanding tags are discarded (downstream FIFOs reset alongside).
//  FSM states: IDLE, CMD, WR0, WR1; grant register g (TAG_W bits).
//  IDLE: if |req and tag FIFO not full: g <= first i with req[i], searching last_grant+1 upward modulo NREQ; -> CMD.
//   Otherwise stay. One-cycle arbitration latency; nothing passes downstream in IDLE.
//  CMD: req_af_full[g]=af_full. af_wr_en=req_af_wr_en[g]&~af_full; af_cmd/addr = slice g, combinational pass-through.
//   On accept: read -> push g into tag FIFO, last_grant<=g, -> IDLE. write -> WR0. Any other cmd treated as write.
//   req[g] dropping before accept -> IDLE, last_grant unchanged.
//  WR0/WR1: req_wdf_full[g]=wdf_full. wdf_wr_en=req_wdf_wr_en[g]&~wdf_full; data/mask = slice g.
//   Accept in WR0 -> WR1; accept in WR1 -> last_grant<=g, -> IDLE. Exactly 2 beats per write (burst of 4).
//  Non-granted clients: strobes ignored; their full outputs stay 1.
//  Read return: head = oldest tag. If tag FIFO not empty: req_rdf_valid[head]=rdf_valid;
//   rdf_rd_en=rdf_valid&req_rdf_rd_en[head]. 1-bit beat counter counts pops; second pop clears beat, pops tag.
//   Each read returns exactly 2 beats, in issue order.
//  Tag FIFO empty and rdf_valid=1: rdf_rd_en=0, all req_rdf_valid=0, orphan_err<=1 until reset.
//  Tag push and pop in same cycle: both take effect; outstanding unchanged.
//  Tag full: IDLE grants nothing (writes also wait) until a pop frees an entry.
//  Return path runs independently of the FSM; reads and write data may overlap.
// TESTING
//  1 Reset: rst=0 with req=4'b1111 -> all *_full=1, af_wr_en=0; release, IDLE->CMD grants client 0 next cycle.
//  2 Fairness: req=4'b1111 held, every client issues reads -> grant order 0,1,2,3,0; no client granted twice in a row.
//  3 Write: client 2 write addr 0x100 -> af_cmd_din=0, addr 0x100, then 2 wdf beats data A,B mask 0; back to IDLE.
//  4 Return steering: client1 read, client3 read -> first 2 rdf beats to req_rdf_valid[1], next 2 to [3]; outstanding 2->0.
//  5 Backpressure: af_full=1 in CMD for 5 cycles -> no af_wr_en; wdf_full=1 in WR0 stalls; full pass-through to client.
//  6 Tag full: 8 reads outstanding, req=1 -> no grant; one read returns -> grant issued next cycle; orphan rdf -> orphan_err=1.

Source files
------------

// File: rtl/ddr2_rr_arbiter_if.sv
// Client-side and downstream (af/wdf/rdf) signal bundle for the DDR2 round-robin arbiter.
// The arbiter connects through the slave modport; the client/FIFO side uses master.
interface ddr2_rr_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_af_wr_en;
  logic [3*NREQ-1:0]   req_af_cmd;
  logic [31*NREQ-1:0]  req_af_addr;
  logic [NREQ-1:0]     req_wdf_wr_en;
  logic [128*NREQ-1:0] req_wdf_din;
  logic [16*NREQ-1:0]  req_wdf_mask;
  logic [NREQ-1:0]     req_rdf_rd_en;
  logic [NREQ-1:0]     req_af_full;
  logic [NREQ-1:0]     req_wdf_full;
  logic [NREQ-1:0]     req_rdf_valid;

  logic                af_full;
  logic                wdf_full;
  logic                rdf_valid;
  logic                af_wr_en;
  logic [2:0]          af_cmd_din;
  logic [30:0]         af_addr_din;
  logic                wdf_wr_en;
  logic [127:0]        wdf_din;
  logic [15:0]         wdf_mask_din;
  logic                rdf_rd_en;

  modport slave (
    input  req, req_af_wr_en, req_af_cmd, req_af_addr,
    input  req_wdf_wr_en, req_wdf_din, req_wdf_mask, req_rdf_rd_en,
    output req_af_full, req_wdf_full, req_rdf_valid,
    input  af_full, wdf_full, rdf_valid,
    output af_wr_en, af_cmd_din, af_addr_din,
    output wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
  );

  modport master (
    output req, req_af_wr_en, req_af_cmd, req_af_addr,
    output req_wdf_wr_en, req_wdf_din, req_wdf_mask, req_rdf_rd_en,
    input  req_af_full, req_wdf_full, req_rdf_valid,
    output af_full, wdf_full, rdf_valid,
    input  af_wr_en, af_cmd_din, af_addr_din,
    input  wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
  );
endinterface

// File: rtl/ddr2_rr_arbiter.sv
// Round-robin arbiter sharing the DDR2 af/wdf among NREQ clients, one transaction at a time,
// with an in-order tag FIFO that steers read-data beats back to the issuing client.
module ddr2_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 8,
  parameter int TAG_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  ddr2_rr_arbiter_if.slave  bus,
  output logic [TAG_W+1:0]  outstanding,
  output logic              orphan_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, WR0, WR1} state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   g_q, g_d;
  logic [TAG_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TAG_W+1:0]   cnt_q, cnt_d;
  logic               beat_q, beat_d;
  logic               orphan_q, orphan_d;

  logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_W-1:0]   pick;
  logic [TAG_W-1:0]   head;
  logic               found;
  logic               tag_push;
  logic               tag_pop;
  logic               tag_empty;
  logic               tag_full;

  assign tag_empty   = (cnt_q == '0);
  assign tag_full    = (cnt_q == (TAG_W+2)'(TAG_DEPTH));
  assign head        = tag_mem[rd_ptr_q];
  assign outstanding = cnt_q;
  assign orphan_err  = orphan_q;

  // Search starts just after the last completed grant so every client gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = TAG_W'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    g_d              = g_q;
    last_d           = last_q;
    tag_push         = 1'b0;
    bus.req_af_full  = '1;
    bus.req_wdf_full = '1;
    bus.af_wr_en     = 1'b0;
    bus.wdf_wr_en    = 1'b0;
    bus.af_cmd_din   = bus.req_af_cmd[3*int'(g_q) +: 3];
    bus.af_addr_din  = bus.req_af_addr[31*int'(g_q) +: 31];
    bus.wdf_din      = bus.req_wdf_din[128*int'(g_q) +: 128];
    bus.wdf_mask_din = bus.req_wdf_mask[16*int'(g_q) +: 16];
    case (state_q)
      IDLE: begin
        if (found && !tag_full) begin
          g_d     = pick;
          state_d = CMD;
        end
      end
      CMD: begin
        bus.req_af_full[g_q] = bus.af_full;
        bus.af_wr_en         = bus.req_af_wr_en[g_q] & ~bus.af_full;
        if (bus.af_wr_en) begin
          // Only 3'b001 is a read; anything else carries write data.
          if (bus.af_cmd_din == 3'b001) begin
            tag_push = 1'b1;
            last_d   = g_q;
            state_d  = IDLE;
          end else begin
            state_d  = WR0;
          end
        end else if (!bus.req[g_q]) begin
          state_d = IDLE;
        end
      end
      WR0: begin
        bus.req_wdf_full[g_q] = bus.wdf_full;
        bus.wdf_wr_en         = bus.req_wdf_wr_en[g_q] & ~bus.wdf_full;
        if (bus.wdf_wr_en) state_d = WR1;
      end
      WR1: begin
        bus.req_wdf_full[g_q] = bus.wdf_full;
        bus.wdf_wr_en         = bus.req_wdf_wr_en[g_q] & ~bus.wdf_full;
        if (bus.wdf_wr_en) begin
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return path: independent of the FSM, always serves the oldest outstanding read.
  always_comb begin
    bus.req_rdf_valid = '0;
    bus.rdf_rd_en     = 1'b0;
    if (!tag_empty) begin
      bus.req_rdf_valid[head] = bus.rdf_valid;
      bus.rdf_rd_en           = bus.rdf_valid & bus.req_rdf_rd_en[head];
    end
    tag_pop  = bus.rdf_rd_en & beat_q;
    beat_d   = bus.rdf_rd_en ? ~beat_q : beat_q;
    orphan_d = orphan_q | (tag_empty & bus.rdf_valid);
    wr_ptr_d = tag_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = tag_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({tag_push, tag_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr_q] <= g_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      g_q      <= '0;
      last_q   <= TAG_W'(NREQ - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      orphan_q <= orphan_d;
    end
  end

endmodule

// File: tb/tb_ddr2_rr_arbiter.sv
// Scenario bench for ddr2_rr_arbiter: expected grants, write beats and read-return owners
// are queued as stimulus is driven and popped as the arbiter produces them.
module tb_ddr2_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr2_rr_arbiter_if #(.NREQ(4)) bus ();
  logic [3:0] outstanding;
  logic       orphan_err;

  ddr2_rr_arbiter #(.NREQ(4), .TAG_DEPTH(8), .TAG_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding), .orphan_err(orphan_err)
  );

  logic [2:0]   cl_cmd  [4];
  logic [30:0]  cl_addr [4];
  logic [127:0] cl_data [4];
  logic [15:0]  cl_mask [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign bus.req_af_cmd[3*gi +: 3]      = cl_cmd[gi];
    assign bus.req_af_addr[31*gi +: 31]   = cl_addr[gi];
    assign bus.req_wdf_din[128*gi +: 128] = cl_data[gi];
    assign bus.req_wdf_mask[16*gi +: 16]  = cl_mask[gi];
  end

  int checks = 0;
  int errors = 0;
  int           grant_q[$];
  int           owner_q[$];
  logic [127:0] wdata_q[$];

  localparam logic [127:0] DATA_A = {4{32'hA5A5_0001}};
  localparam logic [127:0] DATA_B = {4{32'h5A5A_0002}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic issue_read(input int c, input logic [30:0] addr);
    bit done = 0;
    cl_cmd[c] = 3'b001;
    cl_addr[c] = addr;
    bus.req[c] = 1'b1;
    bus.req_af_wr_en[c] = 1'b1;
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      samp();
      if (bus.af_wr_en) begin
        checks++;
        if (bus.af_addr_din !== addr || bus.req_af_full !== ~(4'b0001 << c)) begin
          errors++;
          $display("FAIL issue_read c%0d: addr=%h full=%b, want addr=%h full=%b",
                   c, bus.af_addr_din, bus.req_af_full, addr, ~(4'b0001 << c));
        end
        owner_q.push_back(c);
        owner_q.push_back(c);
        done = 1;
      end
      step();
    end
    bus.req[c] = 1'b0;
    bus.req_af_wr_en[c] = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL issue_read c%0d: no af accept within budget", c);
    end
    $display("read issued client=%0d addr=%h outstanding=%0d", c, addr, outstanding);
  endtask

  task automatic drain(input string name);
    int own;
    bus.req_rdf_rd_en = 4'hF;
    bus.rdf_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && owner_q.size() > 0; cyc++) begin
      samp();
      checks++;
      if (!bus.rdf_rd_en) begin
        errors++;
        $display("FAIL %s: rdf_rd_en=0 with %0d beats pending", name, owner_q.size());
      end else begin
        own = owner_q.pop_front();
        if (bus.req_rdf_valid !== 4'(1 << own)) begin
          errors++;
          $display("FAIL %s steer: req_rdf_valid=%b, want %b", name, bus.req_rdf_valid, 4'(1 << own));
        end
        $display("rdf beat to client=%0d valid=%b", own, bus.req_rdf_valid);
      end
      step();
    end
    bus.rdf_valid = 1'b0;
    bus.req_rdf_rd_en = 4'h0;
    if (owner_q.size() > 0) begin
      errors++;
      $display("FAIL %s: %0d beats never returned", name, owner_q.size());
      owner_q.delete();
    end
    samp();
    checks++;
    if (outstanding !== 4'd0) begin
      errors++;
      $display("FAIL %s outstanding: got %0d, want 0", name, outstanding);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 4'hF;
    bus.rdf_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cl_cmd[i] = 3'b001;
      cl_addr[i] = 31'h0;
    end
    step();
    step();
    samp();
    checks++;
    if ({bus.req_af_full, bus.req_wdf_full} !== 8'hFF) begin
      errors++;
      $display("FAIL reset full: af=%b wdf=%b, want 1111 1111", bus.req_af_full, bus.req_wdf_full);
    end
    checks++;
    if ({bus.af_wr_en, bus.wdf_wr_en, bus.rdf_rd_en, bus.req_rdf_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset strobes: af=%b wdf=%b rd=%b rv=%b, want 0", bus.af_wr_en,
               bus.wdf_wr_en, bus.rdf_rd_en, bus.req_rdf_valid);
    end
    checks++;
    if (outstanding !== 4'd0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL reset status: outstanding=%0d orphan=%b, want 0 0", outstanding, orphan_err);
    end
    step();
    rst = 1'b1;
    bus.rdf_valid = 1'b0;
    samp();
    checks++;
    if (bus.req_af_full !== 4'hF) begin
      errors++;
      $display("FAIL reset idle: req_af_full=%b, want 1111", bus.req_af_full);
    end
    step();
    samp();
    checks++;
    if (bus.req_af_full !== 4'b1110) begin
      errors++;
      $display("FAIL reset first grant: req_af_full=%b, want 1110", bus.req_af_full);
    end
    step();
    bus.req = 4'h0;
    step();
    samp();
    checks++;
    if (bus.req_af_full !== 4'hF) begin
      errors++;
      $display("FAIL reset drop: req_af_full=%b, want 1111", bus.req_af_full);
    end
    $display("reset done: first grant client 0 then dropped");
    step();
  endtask

  task automatic test_fairness();
    int n = 0;
    int prev = -1;
    int act;
    int g;
    grant_q = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      cl_cmd[i] = 3'b001;
      cl_addr[i] = 31'h1000 + 31'(i * 'h40);
    end
    bus.req = 4'hF;
    bus.req_af_wr_en = 4'hF;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      samp();
      if (bus.af_wr_en) begin
        g = grant_q.pop_front();
        act = -1;
        for (int i = 0; i < 4; i++) if (bus.req_af_full[i] == 1'b0) act = i;
        checks++;
        if (act !== g || bus.af_addr_din !== 31'h1000 + 31'(g * 'h40)) begin
          errors++;
          $display("FAIL fairness grant: client=%0d addr=%h, want client=%0d addr=%h",
                   act, bus.af_addr_din, g, 31'h1000 + 31'(g * 'h40));
        end
        checks++;
        if (act == prev) begin
          errors++;
          $display("FAIL fairness repeat: client %0d granted twice in a row, want a different client", act);
        end
        $display("fairness grant client=%0d addr=%h", act, bus.af_addr_din);
        prev = act;
        owner_q.push_back(g);
        owner_q.push_back(g);
        n++;
      end
      step();
    end
    bus.req = 4'h0;
    bus.req_af_wr_en = 4'h0;
    if (n < 5) begin
      errors++;
      $display("FAIL fairness: got %0d grants, want 5", n);
    end
    samp();
    checks++;
    if (outstanding !== 4'd5) begin
      errors++;
      $display("FAIL fairness outstanding: got %0d, want 5", outstanding);
    end
    step();
    drain("fairness_return");
  endtask

  task automatic test_write();
    int naf = 0;
    bit beat_seen;
    cl_cmd[2] = 3'b000;
    cl_addr[2] = 31'h100;
    cl_data[2] = DATA_A;
    cl_mask[2] = 16'h0000;
    wdata_q = '{DATA_A, DATA_B};
    bus.req[2] = 1'b1;
    bus.req_af_wr_en[2] = 1'b1;
    bus.req_wdf_wr_en[2] = 1'b1;
    for (int cyc = 0; cyc < 20 && wdata_q.size() > 0; cyc++) begin
      samp();
      beat_seen = 0;
      if (bus.af_wr_en) begin
        naf++;
        checks++;
        if ({bus.af_cmd_din, bus.af_addr_din} !== {3'b000, 31'h100}) begin
          errors++;
          $display("FAIL write cmd: cmd=%b addr=%h, want 000 100", bus.af_cmd_din, bus.af_addr_din);
        end
      end
      if (bus.wdf_wr_en) begin
        checks++;
        if (bus.wdf_din !== wdata_q[0] || bus.wdf_mask_din !== 16'h0 || bus.req_wdf_full !== 4'b1011) begin
          errors++;
          $display("FAIL write beat: din=%h mask=%h full=%b, want din=%h mask=0 full=1011",
                   bus.wdf_din, bus.wdf_mask_din, bus.req_wdf_full, wdata_q[0]);
        end
        $display("write beat din=%h", bus.wdf_din);
        void'(wdata_q.pop_front());
        beat_seen = 1;
      end
      step();
      if (beat_seen) cl_data[2] = DATA_B;
    end
    bus.req[2] = 1'b0;
    bus.req_af_wr_en[2] = 1'b0;
    bus.req_wdf_wr_en[2] = 1'b0;
    if (wdata_q.size() > 0) begin
      errors++;
      $display("FAIL write: %0d beats not accepted", wdata_q.size());
      wdata_q.delete();
    end
    samp();
    checks++;
    if (naf !== 1 || bus.req_af_full !== 4'hF || bus.req_wdf_full !== 4'hF) begin
      errors++;
      $display("FAIL write end: af accepts=%0d af_full=%b wdf_full=%b, want 1 1111 1111",
               naf, bus.req_af_full, bus.req_wdf_full);
    end
    step();
  endtask

  task automatic test_steering();
    issue_read(1, 31'h0123);
    issue_read(3, 31'h0456);
    samp();
    checks++;
    if (outstanding !== 4'd2) begin
      errors++;
      $display("FAIL steering outstanding: got %0d, want 2", outstanding);
    end
    step();
    drain("steering");
  endtask

  task automatic test_backpressure();
    cl_cmd[0] = 3'b000;
    cl_addr[0] = 31'h200;
    cl_data[0] = DATA_A;
    cl_mask[0] = 16'h00FF;
    bus.req[0] = 1'b1;
    bus.req_af_wr_en = 4'b1001;
    bus.req_wdf_wr_en[0] = 1'b1;
    bus.af_full = 1'b1;
    bus.wdf_full = 1'b1;
    samp();
    step();
    for (int i = 0; i < 5; i++) begin
      samp();
      checks++;
      if (bus.af_wr_en !== 1'b0 || bus.req_af_full !== 4'hF) begin
        errors++;
        $display("FAIL bp af stall %0d: af_wr_en=%b full=%b, want 0 1111", i, bus.af_wr_en, bus.req_af_full);
      end
      step();
    end
    bus.af_full = 1'b0;
    samp();
    checks++;
    if (bus.af_wr_en !== 1'b1 || bus.req_af_full !== 4'b1110 || bus.af_addr_din !== 31'h200) begin
      errors++;
      $display("FAIL bp af release: af_wr_en=%b full=%b addr=%h, want 1 1110 200",
               bus.af_wr_en, bus.req_af_full, bus.af_addr_din);
    end
    step();
    bus.req_af_wr_en = 4'h0;
    for (int i = 0; i < 3; i++) begin
      samp();
      checks++;
      if (bus.wdf_wr_en !== 1'b0 || bus.req_wdf_full !== 4'hF) begin
        errors++;
        $display("FAIL bp wdf stall %0d: wdf_wr_en=%b full=%b, want 0 1111", i, bus.wdf_wr_en, bus.req_wdf_full);
      end
      step();
    end
    bus.wdf_full = 1'b0;
    samp();
    checks++;
    if (bus.wdf_wr_en !== 1'b1 || bus.req_wdf_full !== 4'b1110 || bus.wdf_din !== DATA_A
        || bus.wdf_mask_din !== 16'h00FF) begin
      errors++;
      $display("FAIL bp beat0: en=%b full=%b din=%h mask=%h, want 1 1110 %h 00ff",
               bus.wdf_wr_en, bus.req_wdf_full, bus.wdf_din, bus.wdf_mask_din, DATA_A);
    end
    step();
    cl_data[0] = DATA_B;
    samp();
    checks++;
    if (bus.wdf_wr_en !== 1'b1 || bus.wdf_din !== DATA_B) begin
      errors++;
      $display("FAIL bp beat1: en=%b din=%h, want 1 %h", bus.wdf_wr_en, bus.wdf_din, DATA_B);
    end
    step();
    bus.req[0] = 1'b0;
    bus.req_wdf_wr_en[0] = 1'b0;
    samp();
    checks++;
    if (bus.req_wdf_full !== 4'hF || bus.req_af_full !== 4'hF) begin
      errors++;
      $display("FAIL bp end: wdf_full=%b af_full=%b, want 1111 1111", bus.req_wdf_full, bus.req_af_full);
    end
    $display("backpressure write client=0 done");
    step();
  endtask

  task automatic test_tag_full();
    int own;
    for (int i = 0; i < 8; i++) issue_read(i % 4, 31'h2000 + 31'(i));
    samp();
    checks++;
    if (outstanding !== 4'd8) begin
      errors++;
      $display("FAIL tagfull outstanding: got %0d, want 8", outstanding);
    end
    step();
    cl_cmd[1] = 3'b001;
    cl_addr[1] = 31'h3000;
    bus.req[1] = 1'b1;
    bus.req_af_wr_en[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      samp();
      checks++;
      if (bus.af_wr_en !== 1'b0 || bus.req_af_full !== 4'hF) begin
        errors++;
        $display("FAIL tagfull hold %0d: af_wr_en=%b full=%b, want 0 1111", i, bus.af_wr_en, bus.req_af_full);
      end
      step();
    end
    bus.rdf_valid = 1'b1;
    bus.req_rdf_rd_en = 4'hF;
    for (int i = 0; i < 2; i++) begin
      samp();
      own = owner_q.pop_front();
      checks++;
      if (bus.rdf_rd_en !== 1'b1 || bus.req_rdf_valid !== 4'(1 << own)) begin
        errors++;
        $display("FAIL tagfull return %0d: rd_en=%b valid=%b, want 1 %b", i, bus.rdf_rd_en,
                 bus.req_rdf_valid, 4'(1 << own));
      end
      step();
    end
    bus.rdf_valid = 1'b0;
    bus.req_rdf_rd_en = 4'h0;
    samp();
    step();
    samp();
    checks++;
    if (bus.af_wr_en !== 1'b1 || bus.req_af_full !== 4'b1101 || bus.af_addr_din !== 31'h3000) begin
      errors++;
      $display("FAIL tagfull regrant: af_wr_en=%b full=%b addr=%h, want 1 1101 3000",
               bus.af_wr_en, bus.req_af_full, bus.af_addr_din);
    end
    owner_q.push_back(1);
    owner_q.push_back(1);
    step();
    bus.req[1] = 1'b0;
    bus.req_af_wr_en[1] = 1'b0;
    samp();
    checks++;
    if (outstanding !== 4'd8) begin
      errors++;
      $display("FAIL tagfull refill: outstanding=%0d, want 8", outstanding);
    end
    step();
    drain("tagfull_drain");
  endtask

  task automatic test_orphan();
    samp();
    checks++;
    if (orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL orphan pre: orphan_err=%b, want 0", orphan_err);
    end
    step();
    bus.rdf_valid = 1'b1;
    bus.req_rdf_rd_en = 4'hF;
    samp();
    checks++;
    if (bus.rdf_rd_en !== 1'b0 || bus.req_rdf_valid !== 4'h0) begin
      errors++;
      $display("FAIL orphan steer: rd_en=%b valid=%b, want 0 0000", bus.rdf_rd_en, bus.req_rdf_valid);
    end
    step();
    bus.rdf_valid = 1'b0;
    bus.req_rdf_rd_en = 4'h0;
    step();
    step();
    samp();
    checks++;
    if (orphan_err !== 1'b1) begin
      errors++;
      $display("FAIL orphan sticky: orphan_err=%b, want 1", orphan_err);
    end
    $display("orphan beat flagged orphan_err=%b", orphan_err);
    step();
  endtask

  initial begin
    bus.req = '0;
    bus.req_af_wr_en = '0;
    bus.req_wdf_wr_en = '0;
    bus.req_rdf_rd_en = '0;
    bus.af_full = 1'b0;
    bus.wdf_full = 1'b0;
    bus.rdf_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cl_cmd[i] = '0;
      cl_addr[i] = '0;
      cl_data[i] = '0;
      cl_mask[i] = '0;
    end
    test_reset();
    test_fairness();
    test_write();
    test_steering();
    test_backpressure();
    test_tag_full();
    test_orphan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
